// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared constants and types for the PC sequencer.
//   XLEN            architectural PC width (only 32 is supported)
//   RESET_VEC_DEF   default PC after reset
//   TRAP_VEC_DEF    default PC taken on a misaligned control transfer
//   seq_state_e     sequencer state encoding (BOOT/RUN/HALT/TRAP)
//   redirect_t      control-transfer request bundle fed to pc_next_mux
package pc_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;

  localparam logic [XLEN-1:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VEC_DEF  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic            jalr;
    logic [XLEN-1:0] jalr_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
  } redirect_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between the decode/branch logic
// (master) and the PC sequencer (slave).
//   master drives: stall, branch_*, jump*, jalr*, halt_req, resume
//   slave drives : pc, pc_plus4, fetch_valid, halted, trap, epc, state
//                  (+ cycle_cnt, instret_cnt when PC_SEQ_PERF_CNT_EN is defined)
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            jalr;
  logic [XLEN-1:0] jalr_target;
  logic            halt_req;
  logic            resume;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_valid;
  logic            halted;
  logic            trap;
  logic [XLEN-1:0] epc;
  logic [1:0]      state;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
`endif

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           jalr, jalr_target, halt_req, resume,
`ifdef PC_SEQ_PERF_CNT_EN
    input  cycle_cnt, instret_cnt,
`endif
    input  pc, pc_plus4, fetch_valid, halted, trap, epc, state
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           jalr, jalr_target, halt_req, resume,
`ifdef PC_SEQ_PERF_CNT_EN
    output cycle_cnt, instret_cnt,
`endif
    output pc, pc_plus4, fetch_valid, halted, trap, epc, state
  );

endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC select.
//   pc                  current fetch address
//   req                 redirect requests/targets (redirect_t)
//   next_pc             jalr > jump > branch > pc+4 (jalr bit 0 cleared)
//   redirect_misaligned a redirect was selected and its target is not 4-byte aligned
module pc_next_mux
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  redirect_t       req,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect_misaligned
);

  logic redirect;

  // Priority select; the sequential path is always aligned so it never traps.
  always_comb begin
    redirect = 1'b1;
    if (req.jalr) begin
      next_pc = {req.jalr_target[XLEN-1:1], 1'b0};
    end else if (req.jump) begin
      next_pc = req.jump_target;
    end else if (req.branch_taken) begin
      next_pc = req.branch_target;
    end else begin
      next_pc  = pc + XLEN'(4);
      redirect = 1'b0;
    end
  end

  assign redirect_misaligned = redirect && (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and sequences fetch addresses.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   pc_sequencer_if.slave (redirect/stall/halt inputs, pc/status outputs)
// Optional: define PC_SEQ_PERF_CNT_EN to add 64-bit cycle_cnt/instret_cnt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [XLEN-1:0] TRAP_VEC  = TRAP_VEC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.slave   bus
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            trap_q, trap_d;
  logic            halted_q, halted_d;

  redirect_t       req;
  logic [XLEN-1:0] mux_pc;
  logic            misaligned;

  assign req = '{
    jalr:          bus.jalr,
    jalr_target:   bus.jalr_target,
    jump:          bus.jump,
    jump_target:   bus.jump_target,
    branch_taken:  bus.branch_taken,
    branch_target: bus.branch_target
  };

  pc_next_mux u_next_mux (
    .pc                  (pc_q),
    .req                 (req),
    .next_pc             (mux_pc),
    .redirect_misaligned (misaligned)
  );

  // Next-state / next-register logic; everything holds unless a case says otherwise.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.stall) begin
          if (misaligned) begin
            pc_d    = TRAP_VEC;
            epc_d   = pc_q;
            state_d = ST_TRAP;
          end else begin
            pc_d = mux_pc;
            if (bus.halt_req) state_d = ST_HALT;
          end
        end
      end
      ST_HALT: if (bus.resume) state_d = ST_RUN;
      ST_TRAP: state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    trap_d   = (state_d == ST_TRAP);
    halted_d = (state_d == ST_HALT);
  end

  // State and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      trap_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      trap_q   <= trap_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + XLEN'(4);
  assign bus.fetch_valid = (state_q == ST_RUN);
  assign bus.halted      = halted_q;
  assign bus.trap        = trap_q;
  assign bus.epc         = epc_q;
  assign bus.state       = 2'(state_q);

`ifdef PC_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  // Retired count includes the instruction that traps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == ST_RUN && !bus.stall) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios followed by randomized stimulus, all
// checked each cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state (mode numbers follow the visible state encoding).
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  longint unsigned m_cyc;
  longint unsigned m_ins;

  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic jr, input logic [31:0] jrt,
                       input logic hr, input logic rs);
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = jp;
    bus.jump_target   = jt;
    bus.jalr          = jr;
    bus.jalr_target   = jrt;
    bus.halt_req      = hr;
    bus.resume        = rs;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Advance the model by one clock using the currently applied inputs.
  task automatic model_step();
    logic [31:0] tgt;
    logic        redir;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_epc = 32'h0; m_cyc = 0; m_ins = 0;
    end else begin
      m_cyc++;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (!bus.stall) begin
          m_ins++;
          redir = 1'b1;
          if (bus.jalr)              tgt = bus.jalr_target & ~32'd1;
          else if (bus.jump)         tgt = bus.jump_target;
          else if (bus.branch_taken) tgt = bus.branch_target;
          else begin
            tgt = m_pc + 32'd4;
            redir = 1'b0;
          end
          if (redir && (tgt % 4 != 0)) begin
            m_epc  = m_pc;
            m_pc   = 32'h100;
            m_mode = 3;
          end else begin
            m_pc   = tgt;
            m_mode = bus.halt_req ? 2 : 1;
          end
        end
      end else if (m_mode == 2) begin
        if (bus.resume) m_mode = 1;
      end else begin
        m_mode = 1;
      end
    end
  endtask

  task automatic compare();
    check("pc",          64'(bus.pc),          64'(m_pc));
    check("pc_plus4",    64'(bus.pc_plus4),    64'(32'(m_pc + 32'd4)));
    check("fetch_valid", 64'(bus.fetch_valid), 64'(m_mode == 1));
    check("halted",      64'(bus.halted),      64'(m_mode == 2));
    check("trap",        64'(bus.trap),        64'(m_mode == 3));
    check("epc",         64'(bus.epc),         64'(m_epc));
    check("state",       64'(bus.state),       64'(m_mode));
`ifdef PC_SEQ_PERF_CNT_EN
    check("cycle_cnt",   bus.cycle_cnt,        m_cyc);
    check("instret_cnt", bus.instret_cnt,      m_ins);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  function automatic logic [31:0] rnd_target();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    tick();
    check("rst_pc", 64'(bus.pc), 64'h0);
    check("rst_state", 64'(bus.state), 64'd0);
    check("rst_fv", 64'(bus.fetch_valid), 64'd0);
    rst = 1'b0;

    // Boot bubble then sequential fetch.
    tick();
    check("boot_pc", 64'(bus.pc), 64'h0);
    check("boot_fv", 64'(bus.fetch_valid), 64'd1);
    tick(); check("seq_pc4", 64'(bus.pc), 64'h4);
    tick(); check("seq_pc8", 64'(bus.pc), 64'h8);
    tick(); tick();
    check("at_10", 64'(bus.pc), 64'h10);

    // jalr beats jump, bit 0 cleared.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h41, 1'b0, 1'b0);
    tick(); check("jalr_prio", 64'(bus.pc), 64'h40);

    // Misaligned branch traps.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); check("at_20", 64'(bus.pc), 64'h20);
    drive(1'b0, 1'b1, 32'h22, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("trap_pc", 64'(bus.pc), 64'h100);
    check("trap_epc", 64'(bus.epc), 64'h20);
    check("trap_pulse", 64'(bus.trap), 64'd1);
    check("trap_state", 64'(bus.state), 64'd3);
    idle();
    tick();
    check("trap_end", 64'(bus.trap), 64'd0);
    check("trap_ret_state", 64'(bus.state), 64'd1);
    tick(); check("after_trap_pc", 64'(bus.pc), 64'h104);

    // Stall ignores a pending branch.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", 64'(bus.pc), 64'h30);
    end
    idle();
    tick(); check("stall_release", 64'(bus.pc), 64'h34);

    // Halt, hold, resume (resume wins over halt_req).
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("halt_pc", 64'(bus.pc), 64'h44);
    check("halt_flag", 64'(bus.halted), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick(); check("halt_hold", 64'(bus.pc), 64'h44);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    check("resume_state", 64'(bus.state), 64'd1);
    idle();
    tick(); check("resume_pc", 64'(bus.pc), 64'h48);

    // Wrap at top of address space.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); check("wrap_plus4", 64'(bus.pc_plus4), 64'h0);
    idle();
    tick();
    check("wrap_pc", 64'(bus.pc), 64'h0);
    check("wrap_notrap", 64'(bus.trap), 64'd0);

    // resume outside HALT has no effect.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(); check("resume_run", 64'(bus.pc), 64'h4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, rnd_target(),
            $urandom_range(0, 5) == 0, rnd_target(),
            $urandom_range(0, 7) == 0, rnd_target(),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Controls fetch-address sequencing for the single-cycle RISC-V core and owns the architectural program-counter register.
- Selects the next PC from sequential, branch, JAL and JALR sources.
- Applies stall and halt/resume control.
- Redirects a misaligned control-transfer target to a trap vector and captures the faulting PC.
- Sits between the decode/branch-compare logic and instruction memory.

Parameters:
RESET_VEC, 32'h0000_0000, PC loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap
XLEN, 32, PC width (only 32 is supported)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold PC this cycle
branch_taken  in  1  conditional branch resolved taken
branch_target  in  XLEN  PC+imm for branch
jump  in  1  JAL in execution
jump_target  in  XLEN  PC+imm for JAL
jalr  in  1  JALR in execution
jalr_target  in  XLEN  rs1+imm (bit 0 cleared internally)
halt_req  in  1  level request to halt after current instruction
resume  in  1  leave HALT
pc  out  XLEN  current fetch address (registered)
pc_plus4  out  XLEN  pc+4, modulo 2^32
fetch_valid  out  1  instruction at pc is to be executed
halted  out  1  state==HALT
trap  out  1  one-cycle pulse, misaligned target taken
epc  out  XLEN  PC of the instruction that trapped
state  out  2  BOOT=0, RUN=1, HALT=2, TRAP=3

Behaviour:
- Reset (clk edge with rst=1, overrides everything): pc=RESET_VEC, state=BOOT, epc=0, trap=0, halted=0, fetch_valid=0.
- All registered outputs update on posedge clk; fetch_valid is decoded combinationally from state (1 only in RUN).
- BOOT: pc holds; next state is RUN unconditionally (one bubble cycle after reset).
- RUN next-PC selection, in priority order: jalr, then jump, then branch_taken, then pc_plus4.
- jalr_target is used with bit 0 forced to 0.
- Misalignment: if a redirect source is selected and its target[1:0]!=0:
  - pc<=TRAP_VEC, epc<=pc, trap=1 for the next cycle, state<=TRAP.
  - The sequential path never traps.
- RUN with stall=1: pc, state and epc all hold; halt_req and redirects are ignored that cycle.
- RUN with halt_req=1 and stall=0: the current instruction completes; pc<=next PC (trap rules apply, trap takes priority and state goes to TRAP); otherwise state<=HALT.
- HALT: pc holds, fetch_valid=0. resume=1 gives state<=RUN on the next edge. halt_req is ignored in HALT; resume wins when both are high.
- TRAP: lasts one cycle with fetch_valid=0; trap deasserts and state<=RUN. Inputs are ignored in TRAP.
- Wrap: pc=32'hFFFF_FFFC gives pc_plus4=0; sequential advance wraps to 0 without a trap.
- resume asserted outside HALT: no effect.

Optional Feature:
Macro PC_SEQ_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[63:0] and instret_cnt[63:0].
  - Both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on cycles with state==RUN and stall=0 (including the instruction that traps).
  - Both wrap at 2^64.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package/include pc_seq_pkg:
  - state encoding constants (ST_BOOT, ST_RUN, ST_HALT, ST_TRAP)
  - default RESET_VEC/TRAP_VEC
  - XLEN
- One combinational sub-module pc_next_mux: priority select of the target plus misalign flag (output next_pc, redirect_misaligned).
- State register, pc/epc registers and counters live in pc_sequencer.

Test Plan:
- Reset, then 4 idle cycles: pc=0 for cycles 0–1 (BOOT), then 4, 8; fetch_valid 0 then 1; state 0 then 1.
- At pc=0x10, jalr=1, jalr_target=0x41, jump=1, jump_target=0x80: next pc=0x40 (jalr priority, bit 0 cleared).
- At pc=0x20, branch_taken=1, branch_target=0x22: pc=0x100, epc=0x20, trap pulses one cycle, state 3 then 1, then pc=0x104.
- At pc=0x30, stall=1 for 3 cycles with branch_taken=1: pc stays 0x30; after release without redirect pc=0x34.
- At pc=0x40, halt_req=1: pc=0x44, halted=1 and holds 5 cycles; resume=1 gives RUN, then pc=0x48.
- pc forced to 0xFFFF_FFFC via jump: next pc=0x0, no trap; with PC_SEQ_PERF_CNT_EN, instret_cnt matches the count of non-stalled RUN cycles.
